// File: rtl/riscv_hazard_ctrl.sv
// Hazard and stall controller for a 5-stage RISC-V pipeline.
// Generates EX forwarding selects, load-use and memory wait-state stalls,
// branch/jump flushes, a sticky memory timeout flag and saturating
// stall/flush event counters.
module riscv_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned MAX_WAIT   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteM,
    input  logic                  RegWriteW,
    input  logic                  LoadE,
    input  logic                  PCSrcE,
    input  logic                  MemReqM,
    input  logic                  MemReadyM,
    input  logic                  cnt_clr,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic                  MemTimeout,
    output logic [CNT_W-1:0]      StallCount,
    output logic [CNT_W-1:0]      FlushCount
);

    // Wait counter must be able to hold MAX_WAIT; keep at least one bit when disabled.
    localparam int unsigned WaitW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    typedef enum logic {
        StIdle,
        StWait
    } state_e;

    state_e                 state_q, state_d;
    logic [WaitW-1:0]       waitcnt_q, waitcnt_d;
    logic                   timeout_q, timeout_d;
    logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]       flush_cnt_q, flush_cnt_d;

    logic                   lw_stall;
    logic                   mem_stall;
    logic                   timeout_hit;

    // Select the youngest in-flight producer of a source operand; x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic                  we_m,
        input logic [REG_ADDR_W-1:0] rd_w,
        input logic                  we_w
    );
        if (src != '0 && we_m && rd_m == src) begin
            return 2'b10;
        end else if (src != '0 && we_w && rd_w == src) begin
            return 2'b01;
        end else begin
            return 2'b00;
        end
    endfunction

    // Forwarding selects for both EX operands.
    always_comb begin
        ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end

    // Stall and flush decode from load-use hazard, memory wait state and redirect.
    always_comb begin
        lw_stall    = LoadE && (RdE != '0) && (Rs1D == RdE || Rs2D == RdE);
        timeout_hit = (MAX_WAIT != 0) && (waitcnt_q == WaitW'(MAX_WAIT));
        mem_stall   = (state_q == StIdle && MemReqM && !MemReadyM) ||
                      (state_q == StWait && !MemReadyM && !timeout_hit);
        StallF      = mem_stall | lw_stall;
        StallD      = mem_stall | lw_stall;
        StallE      = mem_stall;
        StallM      = mem_stall;
        FlushW      = mem_stall;
        // D/E are frozen during a memory stall, so redirects wait for release.
        FlushD      = !mem_stall && PCSrcE;
        FlushE      = !mem_stall && (lw_stall || PCSrcE);
    end

    // Memory wait-state FSM next state, wait counter and sticky timeout.
    always_comb begin
        state_d   = state_q;
        waitcnt_d = waitcnt_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (MemReqM && !MemReadyM) begin
                    state_d   = StWait;
                    waitcnt_d = WaitW'(1);
                end
            end
            StWait: begin
                if (MemReadyM) begin
                    state_d   = StIdle;
                    waitcnt_d = '0;
                end else if (timeout_hit) begin
                    // Access is abandoned; the pipeline is released this cycle.
                    state_d   = StIdle;
                    waitcnt_d = '0;
                    timeout_d = 1'b1;
                end else if (waitcnt_q != {WaitW{1'b1}}) begin
                    waitcnt_d = waitcnt_q + WaitW'(1);
                end
            end
            default: begin
                state_d   = StIdle;
                waitcnt_d = '0;
            end
        endcase
    end

    // Saturating event counters; clear wins over increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (StallF && stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if ((FlushD || FlushE) && flush_cnt_q != {CNT_W{1'b1}}) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            waitcnt_q   <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            waitcnt_q   <= waitcnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign MemTimeout = timeout_q;
    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Directed testbench for riscv_hazard_ctrl (CNT_W=4, MAX_WAIT=4).
module tb_riscv_hazard_ctrl;

    localparam int unsigned RW = 5;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM, cnt_clr;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
    logic [CW-1:0] StallCount, FlushCount;

    int n_cmp = 0;
    int n_err = 0;

    riscv_hazard_ctrl #(
        .REG_ADDR_W(RW),
        .CNT_W     (CW),
        .MAX_WAIT  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdE       (RdE),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .LoadE     (LoadE),
        .PCSrcE    (PCSrcE),
        .MemReqM   (MemReqM),
        .MemReadyM (MemReadyM),
        .cnt_clr   (cnt_clr),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .StallF    (StallF),
        .StallD    (StallD),
        .StallE    (StallE),
        .StallM    (StallM),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .FlushW    (FlushW),
        .MemTimeout(MemTimeout),
        .StallCount(StallCount),
        .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM, cnt_clr} = '0;
        #12;
        chk("rst_stallcnt", 32'(StallCount), 0);
        chk("rst_flushcnt", 32'(FlushCount), 0);
        chk("rst_timeout", 32'(MemTimeout), 0);
        chk("rst_stallf", 32'(StallF), 0);
        reset = 1'b1;

        // Forwarding priority and x0 guard
        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        #1 chk("fwdA_m", 32'(ForwardAE), 2);
        RegWriteM = 0;
        #1 chk("fwdA_w", 32'(ForwardAE), 1);
        Rs1E = 0;
        #1 chk("fwdA_x0", 32'(ForwardAE), 0);
        Rs2E = 5; RegWriteM = 1;
        #1 chk("fwdB_m", 32'(ForwardBE), 2);
        RdM = 6;
        #1 chk("fwdB_w", 32'(ForwardBE), 1);
        {Rs2E, RdM, RdW, RegWriteM, RegWriteW} = '0;

        // Load-use stall for one cycle
        tick();
        LoadE = 1; RdE = 3; Rs2D = 3;
        #1;
        chk("lw_stallf", 32'(StallF), 1);
        chk("lw_stalld", 32'(StallD), 1);
        chk("lw_flushe", 32'(FlushE), 1);
        chk("lw_flushd", 32'(FlushD), 0);
        chk("lw_stalle", 32'(StallE), 0);
        tick();
        LoadE = 0;
        #1;
        chk("lw_cnt_s", 32'(StallCount), 1);
        chk("lw_cnt_f", 32'(FlushCount), 1);
        chk("lw_release", 32'(StallF), 0);
        LoadE = 1; RdE = 0; Rs2D = 0;
        #1 chk("lw_x0", 32'(StallF), 0);
        LoadE = 0;

        // Redirect flush
        PCSrcE = 1;
        #1;
        chk("br_flushd", 32'(FlushD), 1);
        chk("br_flushe", 32'(FlushE), 1);
        tick();
        PCSrcE = 0;
        chk("br_cnt_f", 32'(FlushCount), 2);
        chk("br_cnt_s", 32'(StallCount), 1);

        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        chk("clr_s", 32'(StallCount), 0);
        chk("clr_f", 32'(FlushCount), 0);

        // Three wait cycles with a redirect pending
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("mw_stallf", 32'(StallF), 1);
            chk("mw_stallm", 32'(StallM), 1);
            chk("mw_flushw", 32'(FlushW), 1);
            chk("mw_flushd", 32'(FlushD), 0);
            tick();
        end
        MemReadyM = 1;
        #1;
        chk("mw_rdy_stallf", 32'(StallF), 0);
        chk("mw_rdy_stalle", 32'(StallE), 0);
        chk("mw_rdy_flushd", 32'(FlushD), 1);
        tick();
        MemReqM = 0; MemReadyM = 0; PCSrcE = 0;
        #1;
        chk("mw_cnt_s", 32'(StallCount), 3);
        chk("mw_cnt_f", 32'(FlushCount), 1);
        chk("mw_idle", 32'(StallF), 0);

        // Timeout after MAX_WAIT cycles
        MemReqM = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_stall", 32'(StallF), 1);
            tick();
        end
        chk("to_release", 32'(StallF), 0);
        chk("to_flag_pre", 32'(MemTimeout), 0);
        MemReqM = 0;
        tick();
        chk("to_flag", 32'(MemTimeout), 1);
        chk("to_idle", 32'(StallF), 0);
        chk("to_cnt_s", 32'(StallCount), 7);
        tick();
        chk("to_sticky", 32'(MemTimeout), 1);

        // Counter saturation
        LoadE = 1; RdE = 3; Rs1D = 3;
        for (int i = 0; i < 20; i++) tick();
        LoadE = 0;
        chk("sat_s", 32'(StallCount), 15);
        chk("sat_f", 32'(FlushCount), 15);
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        chk("sat_clr_s", 32'(StallCount), 0);
        chk("sat_clr_f", 32'(FlushCount), 0);

        // Asynchronous reset during WAIT
        MemReqM = 1; MemReadyM = 0;
        tick();
        MemReqM = 0;
        #1;
        chk("ar_wait_stall", 32'(StallF), 1);
        chk("ar_wait_cnt", 32'(StallCount), 1);
        reset = 0;
        #1;
        chk("ar_stallf", 32'(StallF), 0);
        chk("ar_stalle", 32'(StallE), 0);
        chk("ar_flushw", 32'(FlushW), 0);
        chk("ar_cnt_s", 32'(StallCount), 0);
        chk("ar_timeout", 32'(MemTimeout), 0);
        #2 reset = 1;
        tick();
        chk("ar_post_stall", 32'(StallF), 0);
        chk("ar_post_to", 32'(MemTimeout), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
